// File: rtl/tc_tile_loader_if.sv
// Row-in / tile-out handshake bundle for the tensor core operand tile loader.
// The slave modport is the loader itself; the master modport is the upstream
// fetch path plus the downstream core acting together as the loader's peer.
interface tc_tile_loader_if #(
    parameter int DWIDTH = 16
);
    // Row side: one matrix row of A, B and C per beat
    logic                   row_valid;
    logic                   row_ready;
    logic                   row_last;
    logic                   c_use;
    logic [4*DWIDTH-1:0]    a_row;
    logic [4*DWIDTH-1:0]    b_row;
    logic [4*DWIDTH-1:0]    c_row;

    // Tile side: one complete 4x4 tile per handshake
    logic                   tile_valid;
    logic                   tile_ready;
    logic                   c_valid;
    logic [16*DWIDTH-1:0]   A_out;
    logic [16*DWIDTH-1:0]   B_out;
    logic [16*DWIDTH-1:0]   C_out;

    modport master (
        output row_valid, row_last, c_use, a_row, b_row, c_row, tile_ready,
        input  row_ready, tile_valid, c_valid, A_out, B_out, C_out
    );

    modport slave (
        input  row_valid, row_last, c_use, a_row, b_row, c_row, tile_ready,
        output row_ready, tile_valid, c_valid, A_out, B_out, C_out
    );
endinterface

// File: rtl/tc_tile_loader.sv
// Operand tile loader: assembles 4 row beats into a 4x4 A/B/C tile inside a
// two-entry ping-pong buffer and hands finished tiles to the tensor core.
// One buffer can fill while the other drains, so the fetch path only stalls
// when both buffers hold complete tiles that the core has not yet taken.
module tc_tile_loader #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    tc_tile_loader_if.slave     bus,
    output logic                err,
    output logic [CWIDTH-1:0]   tile_cnt
);
    localparam int RW = 4 * DWIDTH;
    localparam int TW = 16 * DWIDTH;

    logic [TW-1:0] a_buf [2];
    logic [TW-1:0] b_buf [2];
    logic [TW-1:0] c_buf [2];
    logic [1:0]    cuse_buf;
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          wp;
    logic          rp;
    logic [1:0]    rcnt;

    logic          row_ready_s;
    logic          accept;
    logic          drain;
    logic          tile_done;
    logic          frame_err;
    logic [1:0]    set_mask;
    logic [1:0]    clr_mask;
    int            row_lo;

    // Handshake decode, row slot position and next full flags
    always_comb begin
        row_ready_s = !full[wp] && !flush && !rst;
        accept      = bus.row_valid && row_ready_s;
        drain       = full[rp] && bus.tile_ready;
        // A beat closes the tile only when it is row 3 and is flagged last;
        // any disagreement between the two is a framing error.
        tile_done   = accept && (rcnt == 2'd3) && bus.row_last;
        frame_err   = accept && ((rcnt == 2'd3) != bus.row_last);
        // Row r lives in the 4*DWIDTH slice starting at (3-r)*4*DWIDTH so that
        // element [0][0] ends up in the MSBs of the packed tile.
        row_lo      = (3 - int'(rcnt)) * RW;
        set_mask    = tile_done ? (2'b01 << wp) : 2'b00;
        clr_mask    = drain     ? (2'b01 << rp) : 2'b00;
        full_next   = (full & ~clr_mask) | set_mask;
    end

    // Present the buffer at the read pointer to the core
    always_comb begin
        bus.row_ready  = row_ready_s;
        bus.tile_valid = full[rp];
        bus.c_valid    = full[rp] && cuse_buf[rp];
        bus.A_out      = a_buf[rp];
        bus.B_out      = b_buf[rp];
        bus.C_out      = c_buf[rp];
    end

    // Tile storage: write the accepted row into its slot of the fill buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
                c_buf[i] <= '0;
            end
            cuse_buf <= 2'b00;
        end else if (accept) begin
            a_buf[wp][row_lo +: RW] <= bus.a_row;
            b_buf[wp][row_lo +: RW] <= bus.b_row;
            c_buf[wp][row_lo +: RW] <= bus.c_row;
            if (rcnt == 2'd0) begin
                cuse_buf[wp] <= bus.c_use;
            end else begin
                cuse_buf[wp] <= cuse_buf[wp];
            end
        end else begin
            cuse_buf <= cuse_buf;
        end
    end

    // Pointers, row counter, full flags, sticky error and hand-off counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 2'b00;
            wp       <= 1'b0;
            rp       <= 1'b0;
            rcnt     <= 2'd0;
            err      <= 1'b0;
            tile_cnt <= '0;
        end else begin
            full <= full_next;

            // flush and accept are exclusive because row_ready is low in flush
            if (flush) begin
                rcnt <= 2'd0;
            end else if (tile_done) begin
                wp   <= ~wp;
                rcnt <= 2'd0;
            end else if (frame_err) begin
                rcnt <= 2'd0;
            end else if (accept) begin
                rcnt <= rcnt + 2'd1;
            end else begin
                rcnt <= rcnt;
            end

            if (frame_err) begin
                err <= 1'b1;
            end else begin
                err <= err;
            end

            if (drain) begin
                rp       <= ~rp;
                tile_cnt <= tile_cnt + CWIDTH'(1);
            end else begin
                rp       <= rp;
                tile_cnt <= tile_cnt;
            end
        end
    end
endmodule

// File: tb/tb_tc_tile_loader.sv
// Self-checking bench for tc_tile_loader: expected tiles are pushed to a
// scoreboard queue as rows are driven, observed tiles are captured at each
// tile handshake, and each scenario task compares the two inline.
module tb_tc_tile_loader;
    localparam int DW = 16;

    typedef struct packed {
        logic [16*DW-1:0] a;
        logic [16*DW-1:0] b;
        logic [16*DW-1:0] c;
        logic             cv;
    } tile_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        err;
    logic [15:0] tile_cnt;

    tc_tile_loader_if #(.DWIDTH(DW)) bus ();

    tc_tile_loader #(.DWIDTH(DW), .CWIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .err      (err),
        .tile_cnt (tile_cnt)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    tile_t exp_q[$];
    tile_t obs_q[$];
    bit    acc_flag;

    function automatic logic [15:0] elem(int seed, int m, int r, int c);
        if (seed == 0) return 16'(4 * r + c);
        return {6'(seed), 2'(m), 4'(r), 4'(c)};
    endfunction

    function automatic tile_t make_tile(int seed, bit cu);
        tile_t t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t.a[(15 - (4 * r + c)) * DW +: DW] = elem(seed, 0, r, c);
                t.b[(15 - (4 * r + c)) * DW +: DW] = elem(seed, 1, r, c);
                t.c[(15 - (4 * r + c)) * DW +: DW] = elem(seed, 2, r, c);
            end
        end
        t.cv = cu;
        return t;
    endfunction

    // One clock: sample handshakes on the falling edge, return 1 after rise.
    task automatic tick();
        tile_t t;
        @(negedge clk);
        acc_flag = bus.row_valid && bus.row_ready;
        if (bus.tile_valid && bus.tile_ready) begin
            t = {bus.A_out, bus.B_out, bus.C_out, bus.c_valid};
            obs_q.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(int seed, int r, bit cu, bit last);
        for (int c = 0; c < 4; c++) begin
            bus.a_row[(3 - c) * DW +: DW] = elem(seed, 0, r, c);
            bus.b_row[(3 - c) * DW +: DW] = elem(seed, 1, r, c);
            bus.c_row[(3 - c) * DW +: DW] = elem(seed, 2, r, c);
        end
        bus.c_use     = cu;
        bus.row_last  = last;
        bus.row_valid = 1'b1;
    endtask

    task automatic send_row(int seed, int r, bit cu, bit last, output int waits);
        drive_row(seed, r, cu, last);
        waits = 0;
        do begin
            tick();
            waits++;
        end while (!acc_flag && waits < 50);
        if (!acc_flag) begin
            n_checks++;
            n_fail++;
            $display("FAIL row_accept_timeout: seed %0d row %0d not accepted in %0d cycles", seed, r, waits);
        end
    endtask

    task automatic send_tile(int seed, bit cu, output int waits);
        int w;
        exp_q.push_back(make_tile(seed, cu));
        waits = 0;
        for (int r = 0; r < 4; r++) begin
            send_row(seed, r, cu, (r == 3), w);
            waits += w;
        end
    endtask

    task automatic idle();
        bus.row_valid = 1'b0;
        bus.row_last  = 1'b0;
    endtask

    task automatic wait_obs(int n);
        int k = 0;
        while (obs_q.size() < n && k < 100) begin
            tick();
            k++;
        end
        if (obs_q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL tile_wait_timeout: got %0d tiles, need %0d", obs_q.size(), n);
        end
    endtask

    task automatic do_reset();
        idle();
        flush = 1'b0;
        bus.tile_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.tile_ready = 1'b0;
        bus.c_use = 1'b0;
        bus.a_row = '0;
        bus.b_row = '0;
        bus.c_row = '0;
        idle();
        @(posedge clk);
        #1;
        tick();
        n_checks++;
        if (bus.row_ready !== 1'b0) begin n_fail++; $display("FAIL reset_row_ready: got %b exp 0", bus.row_ready); end
        n_checks++;
        if (bus.tile_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tile_valid: got %b exp 0", bus.tile_valid); end
        n_checks++;
        if (bus.c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c_valid: got %b exp 0", bus.c_valid); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err); end
        n_checks++;
        if (tile_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_tile_cnt: got %0d exp 0", tile_cnt); end
        n_checks++;
        if ({bus.A_out, bus.B_out, bus.C_out} !== {(48*DW){1'b0}}) begin
            n_fail++; $display("FAIL reset_data: A/B/C not all zero");
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.row_ready !== 1'b1) begin n_fail++; $display("FAIL release_row_ready: got %b exp 1", bus.row_ready); end
    endtask

    task automatic test_single_tile();
        int w;
        tile_t e, o;
        bus.tile_ready = 1'b1;
        send_tile(0, 1'b1, w);
        idle();
        n_checks++;
        if (bus.tile_valid !== 1'b1) begin n_fail++; $display("FAIL single_tile_valid: got %b exp 1", bus.tile_valid); end
        n_checks++;
        if (bus.c_valid !== 1'b1) begin n_fail++; $display("FAIL single_c_valid: got %b exp 1", bus.c_valid); end
        n_checks++;
        if (bus.A_out[255:240] !== 16'h0000) begin n_fail++; $display("FAIL single_a00: got %h exp 0000", bus.A_out[255:240]); end
        n_checks++;
        if (bus.A_out[15:0] !== 16'h000F) begin n_fail++; $display("FAIL single_a33: got %h exp 000f", bus.A_out[15:0]); end
        tick();
        tick();
        n_checks++;
        if (bus.tile_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b exp 0", bus.tile_valid); end
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_one_handshake: got %0d exp 1", obs_q.size()); end
        n_checks++;
        if (tile_cnt !== 16'd1) begin n_fail++; $display("FAIL single_tile_cnt: got %0d exp 1", tile_cnt); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL single_tile_data: got %h exp %h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        int w, total;
        bit any_acc;
        tile_t e, o;
        bus.tile_ready = 1'b0;
        exp_q.push_back(make_tile(1, 1'b1));
        exp_q.push_back(make_tile(2, 1'b0));
        exp_q.push_back(make_tile(3, 1'b1));
        total = 0;
        for (int r = 0; r < 4; r++) begin send_row(1, r, 1'b1, (r == 3), w); total += w; end
        for (int r = 0; r < 4; r++) begin send_row(2, r, 1'b0, (r == 3), w); total += w; end
        n_checks++;
        if (total != 8) begin n_fail++; $display("FAIL bp_fill_cycles: got %0d exp 8", total); end
        n_checks++;
        if (bus.row_ready !== 1'b0) begin n_fail++; $display("FAIL bp_row_ready_low: got %b exp 0", bus.row_ready); end
        drive_row(3, 0, 1'b1, 1'b0);
        any_acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            any_acc |= acc_flag;
        end
        n_checks++;
        if (any_acc !== 1'b0) begin n_fail++; $display("FAIL bp_stall: row accepted while both buffers full"); end
        bus.tile_ready = 1'b1;
        send_row(3, 0, 1'b1, 1'b0, w);
        n_checks++;
        if (w != 2) begin n_fail++; $display("FAIL bp_resume_latency: got %0d cycles exp 2", w); end
        send_row(3, 1, 1'b1, 1'b0, w);
        n_checks++;
        if (w != 1) begin n_fail++; $display("FAIL bp_row10_latency: got %0d cycles exp 1", w); end
        send_row(3, 2, 1'b1, 1'b0, w);
        send_row(3, 3, 1'b1, 1'b1, w);
        idle();
        wait_obs(3);
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bp_tile_order: got %h exp %h", o, e); end
        end
    endtask

    task automatic test_streaming();
        int w, total;
        tile_t e, o;
        do_reset();
        bus.tile_ready = 1'b1;
        total = 0;
        for (int t = 0; t < 8; t++) begin
            send_tile(10 + t, (t % 2 == 0), w);
            total += w;
        end
        idle();
        wait_obs(8);
        tick();
        n_checks++;
        if (total != 32) begin n_fail++; $display("FAIL stream_no_bubbles: got %0d cycles exp 32", total); end
        n_checks++;
        if (tile_cnt !== 16'd8) begin n_fail++; $display("FAIL stream_tile_cnt: got %0d exp 8", tile_cnt); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL stream_tile: got %h exp %h", o, e); end
        end
    endtask

    task automatic test_framing();
        int w;
        tile_t e, o;
        do_reset();
        bus.tile_ready = 1'b1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clear: got %b exp 0", err); end
        send_row(20, 0, 1'b1, 1'b0, w);
        send_row(20, 1, 1'b1, 1'b1, w);
        idle();
        tick();
        tick();
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL frame_premature_err: got %b exp 1", err); end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL frame_premature_drop: got %0d tiles exp 0", obs_q.size()); end
        send_tile(21, 1'b0, w);
        idle();
        wait_obs(1);
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL frame_recover_tile: got %h exp %h", o, e); end
        end
        for (int r = 0; r < 4; r++) send_row(22, r, 1'b1, 1'b0, w);
        idle();
        tick();
        tick();
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL frame_missing_drop: got %0d tiles exp 0", obs_q.size()); end
        send_tile(23, 1'b1, w);
        idle();
        wait_obs(1);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL frame_err_sticky: got %b exp 1", err); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL frame_missing_recover: got %h exp %h", o, e); end
        end
    endtask

    task automatic test_flush();
        int w;
        tile_t e, o;
        do_reset();
        bus.tile_ready = 1'b0;
        send_tile(30, 1'b1, w);
        send_row(31, 0, 1'b0, 1'b0, w);
        send_row(31, 1, 1'b0, 1'b0, w);
        drive_row(31, 2, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        n_checks++;
        if (acc_flag !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_row: got accepted=%b exp 0", acc_flag); end
        flush = 1'b0;
        idle();
        bus.tile_ready = 1'b1;
        send_tile(32, 1'b0, w);
        idle();
        wait_obs(2);
        tick();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got %b exp 0", err); end
        n_checks++;
        if (tile_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_tile_cnt: got %0d exp 2", tile_cnt); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL flush_tile: got %h exp %h", o, e); end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL flush_extra_tiles: got %0d extra", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int w;
        tile_t e, o;
        bus.tile_ready = 1'b0;
        send_tile(33, 1'b1, w);
        send_row(34, 0, 1'b1, 1'b0, w);
        send_row(34, 1, 1'b1, 1'b0, w);
        idle();
        n_checks++;
        if (bus.tile_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b exp 1", bus.tile_valid); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.tile_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tile_valid: got %b exp 0", bus.tile_valid); end
        n_checks++;
        if (bus.c_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_c_valid: got %b exp 0", bus.c_valid); end
        n_checks++;
        if (tile_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_tile_cnt: got %0d exp 0", tile_cnt); end
        n_checks++;
        if (bus.row_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_row_ready: got %b exp 0", bus.row_ready); end
        n_checks++;
        if (bus.A_out !== {(16*DW){1'b0}}) begin n_fail++; $display("FAIL midrst_a_out: got %h exp 0", bus.A_out); end
        tick();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        bus.tile_ready = 1'b1;
        send_tile(35, 1'b1, w);
        idle();
        wait_obs(1);
        tick();
        n_checks++;
        if (tile_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_after_cnt: got %0d exp 1", tile_cnt); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_after_tile: got %h exp %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_backpressure();
        test_streaming();
        test_framing();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
